dataflow_stage_sequencer: RTL and testbench

Run-level controller for the two-stage streaming pipeline (stage 0 = zero-padding, stage 1 = 2-D convolution). It accepts a multi-frame run request from the host, issues per-frame start handshakes to both stages, and tracks the stage-0 → stage-1 start tokens in place of an external start FIFO. It counts completed frames, signals run completion, and runs a per-stage stall watchdog on the stages' stream-blocked indications. This gives a hardware stall flag alongside the simulation-only deadlock detector.

---
 rtl/dataflow_seq_pkg.sv | 18 +
 rtl/stall_watchdog.sv | 37 +++
 rtl/dataflow_stage_sequencer.sv | 152 +++++++++++++++
 tb/tb_dataflow_stage_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_seq_pkg.sv
// rtl/dataflow_seq_pkg.sv - shared types and constants for the two-stage run sequencer
package dataflow_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int STAGE_PAD  = 0;
    localparam int STAGE_CONV = 1;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int token_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// rtl/stall_watchdog.sv - consecutive-blocked-cycle counter for one pipeline stage
module stall_watchdog #(
    parameter int WDOG_W     = 20,
    parameter int WDOG_LIMIT = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic blk,
    input  logic clear,
    output logic stall_hit
);

    localparam logic [WDOG_W-1:0] LIMIT    = WDOG_W'(WDOG_LIMIT);
    localparam logic [WDOG_W-1:0] LIMIT_M1 = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] r_cnt;

    // Fires on the cycle whose closing edge brings the count to the limit,
    // so the parent's sticky bit lands on that same edge.
    assign stall_hit = enable & blk & (r_cnt >= LIMIT_M1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            if (!blk) begin
                r_cnt <= '0;
            end else if (r_cnt != LIMIT) begin
                r_cnt <= r_cnt + WDOG_W'(1);
            end
        end
    end

endmodule

// File: rtl/dataflow_stage_sequencer.sv
// rtl/dataflow_stage_sequencer.sv - multi-frame run controller for the pad/conv pipeline
module dataflow_stage_sequencer
    import dataflow_seq_pkg::*;
#(
    parameter int TOKEN_DEPTH = 2,
    parameter int FRAME_W     = 16,
    parameter int WDOG_W      = 20,
    parameter int WDOG_LIMIT  = 100000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              ap_start,
    input  logic [FRAME_W-1:0]                frame_count,
    output logic                              ap_ready,
    output logic                              ap_done,
    output logic                              ap_idle,
    output logic                              s0_start,
    input  logic                              s0_ready,
    input  logic                              s0_blk,
    output logic                              s1_start,
    input  logic                              s1_ready,
    input  logic                              s1_done,
    input  logic                              s1_blk,
    output logic [token_w(TOKEN_DEPTH)-1:0]   tokens,
    output logic [FRAME_W-1:0]                frames_done,
    output logic                              stall,
    output logic [1:0]                        stall_stage
);

    localparam int                 TOKEN_W = token_w(TOKEN_DEPTH);
    localparam logic [TOKEN_W-1:0] TOK_MAX = TOKEN_W'(TOKEN_DEPTH);

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic [FRAME_W-1:0]  r_n;
    logic [FRAME_W-1:0]  r_issued0;
    logic [FRAME_W-1:0]  r_issued1;
    logic [FRAME_W-1:0]  r_frames_done;
    logic [TOKEN_W-1:0]  r_tokens;
    logic [1:0]          r_stall_stage;

    logic                w_run;
    logic                w_accept;
    logic                w_hs0;
    logic                w_hs1;
    logic                w_last;
    logic [1:0]          w_blk;
    logic [1:0]          w_hit;

    assign w_run    = (r_state == RUN);
    assign w_accept = (r_state == IDLE) & ap_start;

    // Start requests depend only on registered state; the token count
    // stands in for the stage-0 -> stage-1 start FIFO.
    assign s0_start = w_run & (r_issued0 < r_n) & (r_tokens < TOK_MAX);
    assign s1_start = w_run & (r_tokens != '0) & (r_issued1 < r_n);
    assign w_hs0    = s0_start & s0_ready;
    assign w_hs1    = s1_start & s1_ready;
    assign w_last   = w_run & s1_done & ((r_frames_done + FRAME_W'(1)) == r_n);

    assign tokens      = r_tokens;
    assign frames_done = r_frames_done;
    assign stall_stage = r_stall_stage;
    assign stall       = |r_stall_stage;

    always_comb begin
        w_next   = r_state;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        ap_idle  = 1'b0;
        case (r_state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    ap_ready = 1'b1;
                    w_next   = (frame_count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                ap_done = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_n           <= '0;
            r_issued0     <= '0;
            r_issued1     <= '0;
            r_frames_done <= '0;
            r_tokens      <= '0;
            r_stall_stage <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_n           <= frame_count;
                r_issued0     <= '0;
                r_issued1     <= '0;
                r_frames_done <= '0;
                r_tokens      <= '0;
                r_stall_stage <= '0;
            end else if (w_run) begin
                if (w_hs0) begin
                    r_issued0 <= r_issued0 + FRAME_W'(1);
                end
                if (w_hs1) begin
                    r_issued1 <= r_issued1 + FRAME_W'(1);
                end
                case ({w_hs0, w_hs1})
                    2'b10:   r_tokens <= r_tokens + TOKEN_W'(1);
                    2'b01:   r_tokens <= r_tokens - TOKEN_W'(1);
                    default: r_tokens <= r_tokens;
                endcase
                if (s1_done) begin
                    r_frames_done <= r_frames_done + FRAME_W'(1);
                end
                if (w_hit[STAGE_PAD]) begin
                    r_stall_stage[STAGE_PAD] <= 1'b1;
                end
                if (w_hit[STAGE_CONV]) begin
                    r_stall_stage[STAGE_CONV] <= 1'b1;
                end
            end
        end
    end

    assign w_blk[STAGE_PAD]  = s0_blk;
    assign w_blk[STAGE_CONV] = s1_blk;

    for (genvar g = 0; g < 2; g++) begin : g_wdog
        stall_watchdog #(
            .WDOG_W     (WDOG_W),
            .WDOG_LIMIT (WDOG_LIMIT)
        ) u_wdog (
            .clock     (clock),
            .reset     (reset),
            .enable    (w_run),
            .blk       (w_blk[g]),
            .clear     (w_accept),
            .stall_hit (w_hit[g])
        );
    end

endmodule

// File: tb/tb_dataflow_stage_sequencer.sv
// tb/tb_dataflow_stage_sequencer.sv - randomized model-checked bench for the run sequencer
module tb_dataflow_stage_sequencer;

    localparam int DEPTH = 2;
    localparam int FW    = 16;
    localparam int WW    = 6;
    localparam int LIM   = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          ap_start;
    logic [FW-1:0] frame_count;
    logic          ap_ready, ap_done, ap_idle;
    logic          s0_start, s0_ready, s0_blk;
    logic          s1_start, s1_ready, s1_done, s1_blk;
    logic [1:0]    tokens;
    logic [FW-1:0] frames_done;
    logic          stall;
    logic [1:0]    stall_stage;

    dataflow_stage_sequencer #(
        .TOKEN_DEPTH (DEPTH),
        .FRAME_W     (FW),
        .WDOG_W      (WW),
        .WDOG_LIMIT  (LIM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ap_start    (ap_start),
        .frame_count (frame_count),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .s0_start    (s0_start),
        .s0_ready    (s0_ready),
        .s0_blk      (s0_blk),
        .s1_start    (s1_start),
        .s1_ready    (s1_ready),
        .s1_done     (s1_done),
        .s1_blk      (s1_blk),
        .tokens      (tokens),
        .frames_done (frames_done),
        .stall       (stall),
        .stall_stage (stall_stage)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: a run is N frames; tokens are simply issued0 - issued1;
    // a stage stalls once its current blocked run length reaches LIM.
    bit       m_run, m_done;
    int       m_n, m_i0, m_i1, m_fd;
    int       m_blk_len [2];
    bit [1:0] m_st;
    int       pend[$];
    int       cyc_no;
    int       lat_min, lat_max;
    bit       rand_mode;
    int       obs_hs0, obs_hs1, obs_done, max_tok;

    task automatic model_reset();
        m_run = 0; m_done = 0; m_n = 0; m_i0 = 0; m_i1 = 0; m_fd = 0;
        m_blk_len[0] = 0; m_blk_len[1] = 0; m_st = '0;
        pend.delete();
    endtask

    task automatic clr_obs();
        obs_hs0 = 0; obs_hs1 = 0; obs_done = 0; max_tok = 0;
    endtask

    task automatic cyc();
        bit e_idle, e_s0, e_s1, hs0, hs1;
        bit [1:0] blk;
        if (rand_mode) begin
            s0_ready = ($urandom_range(3, 0) != 0);
            s1_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(4, 0) == 0) s0_blk = ~s0_blk;
            if ($urandom_range(4, 0) == 0) s1_blk = ~s1_blk;
        end
        s1_done = (pend.size() > 0) && (pend[0] <= cyc_no);
        if (s1_done) void'(pend.pop_front());
        @(negedge clock);
        e_idle = !m_run && !m_done;
        e_s0   = m_run && (m_i0 < m_n) && ((m_i0 - m_i1) < DEPTH);
        e_s1   = m_run && ((m_i0 - m_i1) > 0) && (m_i1 < m_n);
        chk("ap_idle", ap_idle, e_idle);
        chk("ap_ready", ap_ready, e_idle && ap_start);
        chk("ap_done", ap_done, m_done);
        chk("s0_start", s0_start, e_s0);
        chk("s1_start", s1_start, e_s1);
        chk("tokens", tokens, m_i0 - m_i1);
        chk("frames_done", frames_done, m_fd);
        chk("stall", stall, |m_st);
        chk("stall_stage", stall_stage, m_st);
        if (s0_start && s0_ready) obs_hs0++;
        if (s1_start && s1_ready) obs_hs1++;
        if (ap_done) obs_done++;
        if (int'(tokens) > max_tok) max_tok = int'(tokens);
        hs0 = e_s0 && s0_ready;
        hs1 = e_s1 && s1_ready;
        blk = {s1_blk, s0_blk};
        if (reset) begin
            model_reset();
        end else if (e_idle) begin
            if (ap_start) begin
                m_n = int'(frame_count);
                m_i0 = 0; m_i1 = 0; m_fd = 0;
                m_blk_len[0] = 0; m_blk_len[1] = 0; m_st = '0;
                if (m_n != 0) m_run = 1; else m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else begin
            if (hs0) m_i0++;
            if (hs1) begin
                m_i1++;
                pend.push_back(cyc_no + int'($urandom_range(lat_max, lat_min)));
            end
            if (s1_done) begin
                m_fd++;
                if (m_fd == m_n) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
            for (int s = 0; s < 2; s++) begin
                m_blk_len[s] = blk[s] ? m_blk_len[s] + 1 : 0;
                if (m_blk_len[s] >= LIM) m_st[s] = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        cyc_no++;
    endtask

    task automatic start_run(input int n);
        ap_start = 1'b1;
        frame_count = FW'(n);
        cyc();
        ap_start = 1'b0;
        frame_count = FW'($urandom);
    endtask

    task automatic run_until_done(input int budget);
        int d0 = obs_done;
        for (int k = 0; k < budget; k++) begin
            cyc();
            if (obs_done != d0) break;
        end
        chk("run_completes", obs_done != d0, 1);
    endtask

    initial begin
        reset = 1'b1; ap_start = 1'b0; frame_count = '0;
        s0_ready = 1'b0; s0_blk = 1'b0; s1_ready = 1'b0; s1_done = 1'b0; s1_blk = 1'b0;
        lat_min = 4; lat_max = 4; rand_mode = 0; cyc_no = 0;
        model_reset();
        clr_obs();
        @(posedge clock);
        #1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // N=3 with ready stages and fixed 4-cycle frame latency
        s0_ready = 1'b1; s1_ready = 1'b1;
        clr_obs();
        start_run(3);
        run_until_done(100);
        cyc();
        cyc();
        chk("n3_hs0", obs_hs0, 3);
        chk("n3_hs1", obs_hs1, 3);
        chk("n3_maxtok_le1", max_tok <= 1, 1);
        chk("n3_frames", frames_done, 3);
        chk("n3_done_pulses", obs_done, 1);

        // N=5 with stage 1 refusing starts: token budget caps stage 0
        s1_ready = 1'b0;
        clr_obs();
        start_run(5);
        repeat (20) cyc();
        chk("bp_tokens", tokens, 2);
        chk("bp_s0_low", s0_start, 0);
        chk("bp_hs0", obs_hs0, 2);
        s1_ready = 1'b1;
        run_until_done(200);
        chk("bp_hs1", obs_hs1, 5);
        chk("bp_frames", frames_done, 5);
        cyc();

        // zero-frame run
        clr_obs();
        start_run(0);
        cyc();
        cyc();
        chk("n0_done", obs_done, 1);
        chk("n0_no_starts", obs_hs0 + obs_hs1, 0);

        // watchdog: 7-cycle burst is harmless, 8 cycles raise stage-1 stall
        s1_ready = 1'b0;
        start_run(10);
        s1_blk = 1'b1;
        repeat (7) cyc();
        s1_blk = 1'b0;
        cyc();
        chk("wd_short_burst", stall, 0);
        s1_blk = 1'b1;
        repeat (8) cyc();
        s1_blk = 1'b0;
        chk("wd_stall", stall, 1);
        chk("wd_stage", stall_stage, 2'b10);
        s1_ready = 1'b1;
        run_until_done(300);
        cyc();
        chk("wd_sticky_idle", stall_stage, 2'b10);
        start_run(1);
        chk("wd_cleared", stall, 0);
        run_until_done(100);
        cyc();

        // asynchronous reset in the middle of a run with tokens full
        s1_ready = 1'b0;
        start_run(5);
        repeat (4) cyc();
        chk("rst_pre_tokens", tokens, 2);
        reset = 1'b1;
        #1;
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", ap_done, 0);
        chk("rst_s0", s0_start, 0);
        chk("rst_tokens", tokens, 0);
        chk("rst_frames", frames_done, 0);
        model_reset();
        cyc();
        reset = 1'b0;
        s1_ready = 1'b1;
        cyc();
        clr_obs();
        start_run(4);
        run_until_done(200);
        chk("post_rst_frames", frames_done, 4);
        cyc();

        // randomized runs: random readiness, blocking bursts and frame latency
        lat_min = 1; lat_max = 7; rand_mode = 1;
        for (int r = 0; r < 16; r++) begin
            start_run(int'($urandom_range(6, 0)));
            run_until_done(600);
            repeat ($urandom_range(2, 0)) cyc();
        end
        rand_mode = 0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
